// File: rtl/key_input_decoder_pkg.sv
// Shared types and timing constants for the key input decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_fsm_e;

  localparam int unsigned CLK_HZ              = 50_000_000;
  // 20 ms of stable level before a new key level is believed
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 50;
  // 1 s of continuous hold marks a long press
  localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/key_input_decoder_if.sv
// Key pins in, debounced level and per-key event pulses out.
// Latency: n/a (signal bundle only).
// Backpressure: none; pulses are one-cycle strobes the consumer must catch.
interface key_input_decoder_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_short;
  logic [NUM_KEYS-1:0] key_long;

  // Board side: drives the pins and watches the events
  modport master (
    output key_raw,
    input  key_state, key_press, key_release, key_short, key_long
  );

  // Decoder side
  modport slave (
    input  key_raw,
    output key_state, key_press, key_release, key_short, key_long
  );
endinterface

// File: rtl/key_debounce_channel.sv
// One key: 2-flop sync, debounce, short/long press classifier.
// Latency: raw edge -> key_state/key_press DEBOUNCE_CYCLES+2 cycles; key_long LONG_CYCLES-1 after key_press.
// Backpressure: none; every event is a single-cycle pulse.
module key_debounce_channel
  import key_input_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_short,
  output logic key_long
);

  // Raw pin level while the key is not pressed
  localparam logic        IDLE_LEVEL = ACTIVE_LOW;
  localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LONG_LAST  = 32'(LONG_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic        synced;
  logic [31:0] db_cnt;
  logic        accept;
  logic        rise;
  logic        fall;
  key_fsm_e    state;
  key_fsm_e    state_next;
  logic [31:0] hold;
  logic [31:0] hold_next;
  logic        short_next;
  logic        long_next;

  // Two-flop synchroniser; polarity is normalised only after the second flop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  assign synced = ACTIVE_LOW ? ~sync2 : sync2;

  // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle
  always_comb begin
    accept = (synced != key_state) && (db_cnt == DB_LAST);
    rise   = accept & synced;
    fall   = accept & ~synced;
  end

  // Debounce counter; any return to the accepted level restarts the count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_state <= 1'b0;
      db_cnt    <= '0;
    end else if (synced == key_state) begin
      db_cnt <= '0;
    end else if (accept) begin
      key_state <= synced;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end

  // Press classifier; a release on the long-threshold cycle counts as short
  always_comb begin
    state_next = state;
    hold_next  = hold;
    short_next = 1'b0;
    long_next  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = PRESSED;
          hold_next  = '0;
        end
      end
      PRESSED: begin
        hold_next = (hold == 32'hFFFF_FFFF) ? hold : hold + 32'd1;
        if (fall) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else if (hold_next == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Classifier state and registered event pulses, aligned with key_state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hold        <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_short   <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      state       <= state_next;
      hold        <= hold_next;
      key_press   <= rise;
      key_release <= fall;
      key_short   <= short_next;
      key_long    <= long_next;
    end
  end

endmodule

// File: rtl/key_input_decoder.sv
// NUM_KEYS independent debounced push-buttons with press/release/short/long events.
// Latency: raw edge -> key_state/key_press DEBOUNCE_CYCLES+2 cycles.
// Backpressure: none; outputs are level + single-cycle pulses.
module key_input_decoder
  import key_input_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  key_input_decoder_if.slave keys
);

  logic [NUM_KEYS-1:0] state_w;
  logic [NUM_KEYS-1:0] press_w;
  logic [NUM_KEYS-1:0] release_w;
  logic [NUM_KEYS-1:0] short_w;
  logic [NUM_KEYS-1:0] long_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_channel (
      .clock       (clock),
      .reset       (reset),
      .key_raw     (keys.key_raw[i]),
      .key_state   (state_w[i]),
      .key_press   (press_w[i]),
      .key_release (release_w[i]),
      .key_short   (short_w[i]),
      .key_long    (long_w[i])
    );
  end

  assign keys.key_state   = state_w;
  assign keys.key_press   = press_w;
  assign keys.key_release = release_w;
  assign keys.key_short   = short_w;
  assign keys.key_long    = long_w;

endmodule

// File: tb/tb_key_input_decoder.sv
// Scoreboard bench for key_input_decoder: 2 keys, active-low, debounce 4, long 16.
// Latency: events expected DB+2 cycles after a raw edge, long LC-1 cycles after press.
// Backpressure: n/a.
module tb_key_input_decoder;

  localparam int NK  = 2;
  localparam int DB  = 4;
  localparam int LC  = 16;
  localparam int LAT = DB + 2;

  typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_SHORT = 2, EV_LONG = 3} ev_kind_e;
  typedef struct {
    int       cyc;
    int       key;
    ev_kind_e kind;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  ev_t           sb[$];
  logic [NK-1:0] model_state = '0;

  key_input_decoder_if #(.NUM_KEYS(NK)) kif ();

  key_input_decoder #(
    .NUM_KEYS        (NK),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LC)
  ) dut (
    .clock (clock),
    .reset (reset),
    .keys  (kif)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void push_ev(input int c, input int k, input ev_kind_e e);
    ev_t ev;
    ev.cyc  = c;
    ev.key  = k;
    ev.kind = e;
    sb.push_back(ev);
  endfunction

  // Raw press starting after cycle n, held h cycles
  function automatic void expect_press(input int n, input int h, input int k);
    push_ev(n + LAT, k, EV_PRESS);
    push_ev(n + h + LAT, k, EV_RELEASE);
    if (h < LC) push_ev(n + h + LAT, k, EV_SHORT);
    else        push_ev(n + LAT + LC - 1, k, EV_LONG);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_press(input int k, input int h);
    int n;
    n = cyc;
    kif.key_raw[k] = 1'b0;
    expect_press(n, h, k);
    step(h);
    kif.key_raw[k] = 1'b1;
    step(LAT + 6);
  endtask

  // Compare every cycle against the events due in that cycle
  always @(negedge clock) begin
    logic [4*NK-1:0] exp_p;
    logic [4*NK-1:0] obs_p;
    exp_p = '0;
    if (reset) begin
      sb.delete();
      model_state = '0;
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          exp_p[int'(sb[i].kind) * NK + sb[i].key] = 1'b1;
          if (sb[i].kind == EV_PRESS)   model_state[sb[i].key] = 1'b1;
          if (sb[i].kind == EV_RELEASE) model_state[sb[i].key] = 1'b0;
          sb.delete(i);
        end
      end
    end
    obs_p = {kif.key_long, kif.key_short, kif.key_release, kif.key_press};
    check_val("pulses", 32'(obs_p), 32'(exp_p));
    check_val("key_state", 32'(kif.key_state), 32'(model_state));
  end

  initial begin
    int n;
    int r;
    // Reset with key 0 already held
    kif.key_raw = 2'b10;
    reset = 1'b1;
    step(3);
    check_val("rst_outputs", 32'({kif.key_state, kif.key_long, kif.key_short,
                                  kif.key_release, kif.key_press}), 32'd0);
    reset = 1'b0;
    r = cyc;
    expect_press(r, 8, 0);
    step(8);
    kif.key_raw[0] = 1'b1;
    step(20);

    // Bounce: 2-cycle pulses, then a single 3-cycle pulse, all rejected
    for (int i = 0; i < 5; i++) begin
      kif.key_raw[0] = 1'b0;
      step(2);
      kif.key_raw[0] = 1'b1;
      step(2);
    end
    step(10);
    kif.key_raw[0] = 1'b0;
    step(DB - 1);
    kif.key_raw[0] = 1'b1;
    step(12);

    // Short, minimum accepted, release-wins boundary, first long, held long
    do_press(0, 10);
    do_press(0, DB);
    do_press(0, LC - 1);
    do_press(0, LC);
    do_press(0, 40);
    do_press(1, 12);

    // Reset 8 cycles into a held press; the key stays held through reset
    n = cyc;
    kif.key_raw[0] = 1'b0;
    push_ev(n + LAT, 0, EV_PRESS);
    step(LAT + 8);
    reset = 1'b1;
    #1;
    check_val("rst_clear", 32'({kif.key_state, kif.key_long, kif.key_short,
                                kif.key_release, kif.key_press}), 32'd0);
    step(3);
    reset = 1'b0;
    r = cyc;
    expect_press(r, 30, 0);
    step(30);
    kif.key_raw[0] = 1'b1;
    step(12);

    // Two keys, 3 cycles apart, both held long
    n = cyc;
    kif.key_raw[0] = 1'b0;
    expect_press(n, 20, 0);
    step(3);
    kif.key_raw[1] = 1'b0;
    expect_press(n + 3, 20, 1);
    step(17);
    kif.key_raw[0] = 1'b1;
    step(3);
    kif.key_raw[1] = 1'b1;
    step(LAT + 6);

    step(5);
    check_val("pending", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
